fft_frame_loader: RTL and testbench
===================================

Name: fft_frame_loader

Overview:
- Upstream feeder for the 64-point FFT core: collects a stream of complex 16-bit samples over a valid/ready handshake into a 64-entry frame buffer.
- Presents the buffer as the parallel inputRe/inputIm arrays, issues a one-cycle start pulse, then times the core's run.
- Frame N+1 may be collected while the core processes frame N. Start is issued only when both the new frame is complete and the previous run has finished.

Parameters:
- N_POINTS, 64, frame length in samples; must equal the FFT D_WIDTH.
- FFT_LATENCY, 224, clock cycles the core needs after start before its outputs are final; must be >= 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  sample valid.
- in_re  in  16  sample real part, two's complement.
- in_im  in  16  sample imaginary part, two's complement.
- in_last  in  1  marks the final sample of a short frame; meaningful only with in_valid.
- in_ifft  in  1  transform direction; sampled with the first sample of each frame.
- in_ready  out  1  loader accepts a sample this cycle.
- frame_re  out  16 x N_POINTS  buffered real samples, to FFT inputRe.
- frame_im  out  16 x N_POINTS  buffered imaginary samples, to FFT inputIm.
- fft_start  out  1  one-cycle start pulse to FFT start.
- fft_ifft  out  1  direction for the frame being processed, to FFT ifft.
- busy  out  1  FFT run in progress.
- done  out  1  one-cycle pulse; FFT outputs are valid.

Behaviour:
- Handshake: a sample is accepted on a posedge where in_valid & in_ready.
  - Write pointer wr_ptr (6 bits) stores the sample at index wr_ptr, then increments.
  - in_valid is not required to be held; data is ignored when in_ready=0.
- Frame completion: a frame is complete when the sample at index N_POINTS-1 is accepted, or when a sample with in_last=1 is accepted.
  - On in_last at index k < 63, entries k+1..63 are written 0 on the same edge, and wr_ptr returns to 0.
  - in_last at index 63 is equivalent to a normal completion.
- Direction: in_ifft is captured into ifft_pend on acceptance of index 0. ifft_pend is copied to fft_ifft when fft_start fires. fft_ifft is held through the run.
- Fill state machine: FILL, FULL.
  - FILL: in_ready=1. On completion, go to FULL if busy=1 or if the core finishes this cycle; otherwise fire start.
  - FULL: in_ready=0. Wait for busy=0, then fire start and return to FILL.
- Run state machine: IDLE, RUN.
  - Fire start: fft_start=1 for exactly one cycle (registered), busy goes 1 on the same edge, and the latency counter loads FFT_LATENCY-1.
  - RUN: counter decrements each cycle. At 0: busy goes 0 and done pulses 1 for one cycle on the same edge.
  - An earliest subsequent start may occur on the cycle after done.
- Frame buffer write rule:
  - frame_re/im must be stable during the fft_start cycle (the core samples them while start is high, including its negedge).
  - Writes to the buffer are therefore blocked on the start cycle. Because in_ready is 0 on that cycle in both FILL-completion and FULL paths, no write is lost.
- Double use: after start the core holds its own copy, so the buffer may be overwritten by the next frame while busy=1.
- Simultaneous events:
  - Completion on the same cycle the counter reaches 0: done pulses this cycle and start fires the next cycle (no overlap of done and fft_start).
  - in_last on index 0: a one-sample frame, remainder zeroed.
- Reset (any time, including mid-fill or mid-run): wr_ptr=0, state FILL/IDLE, in_ready=1 after reset release, fft_start=0, busy=0, done=0, fft_ifft=0, ifft_pend=0, all frame entries 0, counter 0.
- No arithmetic on sample data; samples pass through bit-exact.

Test Plan:
- Reset, then stream 64 samples re=i, im=-i with in_valid held: frame_re[i]=i and frame_im[i]=-i; fft_start pulses exactly once, on the cycle after the 64th acceptance; busy=1 for 224 cycles; done pulses once; in_ready=1 throughout except the start cycle.
- Stream 10 samples re=0x7FFF with in_last on the 10th and in_ifft=1 on the first: entries 0..9 = 0x7FFF and 10..63 = 0; fft_ifft=1 at start.
- Stream frame A, then immediately frame B of 64 samples: B is accepted while busy; the loader enters FULL with in_ready=0 until done for A; start for B fires the cycle after A's done; frame_re holds B during that start.
- Complete a frame exactly on the cycle the counter hits 0: done and fft_start fire on consecutive cycles, never together.
- Toggle in_valid randomly (50%) over a 64-sample frame: the same buffer contents as the back-to-back case; no duplicate or dropped samples.
- Assert rst low mid-run (busy=1, wr_ptr=20): all outputs and the buffer clear immediately; after release, a fresh 64-sample frame starts at index 0 and produces a normal start.

Source files
------------

// File: rtl/fft_frame_loader.sv
// Collects a valid/ready stream of complex 16-bit samples into a frame buffer for the
// 64-point FFT core, then issues its start pulse and times the run.
module fft_frame_loader #(
  parameter int N_POINTS    = 64,
  parameter int FFT_LATENCY = 224
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_re,
  input  logic [15:0] in_im,
  input  logic        in_last,
  input  logic        in_ifft,
  output logic        in_ready,
  output logic [15:0] frame_re [N_POINTS],
  output logic [15:0] frame_im [N_POINTS],
  output logic        fft_start,
  output logic        fft_ifft,
  output logic        busy,
  output logic        done
);

  localparam int PW = $clog2(N_POINTS);
  localparam int CW = $clog2(FFT_LATENCY);
  localparam logic [PW-1:0] LAST_IDX = PW'(N_POINTS - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FFT_LATENCY - 1);

  typedef enum logic {FILL, FULL} fill_state_t;
  typedef enum logic {IDLE, RUN}  run_state_t;

  fill_state_t   fill_state, fill_next;
  run_state_t    run_state, run_next;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          ifft_pend;
  logic          accept, first_sample, complete, run_end, fire_start;

  assign accept       = in_valid & in_ready;
  assign first_sample = accept & (wr_ptr == '0);
  assign complete     = accept & (in_last | (wr_ptr == LAST_IDX));
  assign run_end      = (run_state == RUN) & (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_state <= FILL;
      run_state  <= IDLE;
    end else begin
      fill_state <= fill_next;
      run_state  <= run_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fill_next = fill_state;
    run_next  = run_state;
    case (fill_state)
      FILL:    if (complete && run_state == RUN) fill_next = FULL;
      FULL:    if (run_state == IDLE) fill_next = FILL;
      default: fill_next = FILL;
    endcase
    case (run_state)
      IDLE:    if (fire_start) run_next = RUN;
      RUN:     if (cnt == '0) run_next = IDLE;
      default: run_next = IDLE;
    endcase
  end

  // A core finishing on the completion edge is still RUN here, so that frame goes FULL
  // and starts one cycle after done instead of overlapping it.
  always_comb begin
    in_ready   = (fill_state == FILL) && !fft_start;
    busy       = (run_state == RUN);
    fire_start = (run_state == IDLE) && ((fill_state == FULL) || complete);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      cnt       <= '0;
      fft_start <= 1'b0;
      done      <= 1'b0;
      fft_ifft  <= 1'b0;
      ifft_pend <= 1'b0;
    end else begin
      fft_start <= fire_start;
      done      <= run_end;
      if (accept) wr_ptr <= complete ? '0 : wr_ptr + 1'b1;
      if (first_sample) ifft_pend <= in_ifft;
      if (fire_start) begin
        // A one-sample frame starts on the same edge its direction is captured.
        fft_ifft <= first_sample ? in_ifft : ifft_pend;
        cnt      <= CNT_LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // in_ready is low on the start cycle, so gating writes on accept also keeps the
  // buffer stable while the core samples it.
  // NOTE: the frame buffer is register-based and must read as zero after reset, so it
  // is reset like any other state rather than left as an uninitialised RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_POINTS; i++) begin
        frame_re[i] <= '0;
        frame_im[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N_POINTS; i++) begin
        if (PW'(i) == wr_ptr) begin
          frame_re[i] <= in_re;
          frame_im[i] <= in_im;
        end else if (in_last && (PW'(i) > wr_ptr)) begin
          frame_re[i] <= '0;
          frame_im[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: a frame-level reference model compared
// against the DUT every cycle, plus literal expectations for the directed scenarios.
module tb_fft_frame_loader;

  localparam int N   = 64;
  localparam int LAT = 224;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, in_ifft = 1'b0;
  logic [15:0] in_re = '0, in_im = '0;
  logic        in_ready, fft_start, fft_ifft, busy, done;
  logic [15:0] frame_re [N];
  logic [15:0] frame_im [N];

  fft_frame_loader #(.N_POINTS(N), .FFT_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .in_last(in_last), .in_ifft(in_ifft), .in_ready(in_ready),
    .frame_re(frame_re), .frame_im(frame_im), .fft_start(fft_start),
    .fft_ifft(fft_ifft), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0;
  int start_count = 0, done_count = 0, busy_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a frame waits only while a run is still in progress; a run
  // lasts LAT cycles counted as busy cycles remaining.
  logic [15:0] m_re [N];
  logic [15:0] m_im [N];
  int m_ptr = 0, m_left = 0;
  bit m_wait = 0, m_start = 0, m_done = 0, m_ifft = 0, m_pend = 0;

  function automatic bit m_ready();
    return !m_wait && !m_start;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_re[i] = '0;
      m_im[i] = '0;
    end
    m_ptr = 0; m_left = 0; m_wait = 0; m_start = 0; m_done = 0; m_ifft = 0; m_pend = 0;
  endtask

  task automatic model_step();
    bit acc, comp;
    acc  = in_valid && m_ready();
    comp = acc && (in_last || m_ptr == N - 1);
    m_done = (m_left == 1);
    if (acc) begin
      if (m_ptr == 0) m_pend = in_ifft;
      m_re[m_ptr] = in_re;
      m_im[m_ptr] = in_im;
      if (in_last)
        for (int i = m_ptr + 1; i < N; i++) begin
          m_re[i] = '0;
          m_im[i] = '0;
        end
      m_ptr = comp ? 0 : m_ptr + 1;
    end
    if (comp && m_left > 0) m_wait = 1;
    if ((comp || m_wait) && m_left == 0) begin
      m_wait = 0; m_start = 1; m_left = LAT; m_ifft = m_pend;
    end else begin
      m_start = 0;
      if (m_left > 0) m_left--;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Compare process: outputs are stable at the falling edge.
  initial forever begin
    int fi;
    @(negedge clk);
    check("in_ready", in_ready, m_ready());
    check("fft_start", fft_start, m_start);
    check("busy", busy, m_left > 0);
    check("done", done, m_done);
    check("fft_ifft", fft_ifft, m_ifft);
    check("start_done_overlap", fft_start & done, 0);
    fi = 0;
    for (int i = N - 1; i >= 0; i--)
      if (frame_re[i] !== m_re[i] || frame_im[i] !== m_im[i]) fi = i;
    check($sformatf("frame[%0d]", fi), {frame_re[fi], frame_im[fi]}, {m_re[fi], m_im[fi]});
    if (fft_start) start_count++;
    if (done) done_count++;
    if (busy) busy_cycles++;
  end

  task automatic send(input logic [15:0] re, input logic [15:0] im,
                      input logic last, input logic ifft);
    int  t;
    logic r;
    t = 0;
    in_valid = 1'b1; in_re = re; in_im = im; in_last = last; in_ifft = ifft;
    do begin
      r = in_ready;
      @(posedge clk);
      @(negedge clk);
      t++;
    end while (!r && t < 1000);
    if (!r) check("send_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0; in_ifft = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int t = 0;
    while (!fft_start && t < 2000) begin @(negedge clk); t++; end
    check(name, fft_start, 1);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (!done && t < 2000) begin @(negedge clk); t++; end
    check(name, done, 1);
  endtask

  initial begin
    int s_start, s_done, s_busy, s, errs;
    logic [15:0] a_re [N];
    logic [15:0] a_im [N];

    // Reset state
    #1 rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame0", frame_re[0], 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // T1: full 64-sample frame, valid held
    #1 s_start = start_count; s_done = done_count; s_busy = busy_cycles;
    for (int i = 0; i < N; i++) send(16'(i), 16'(-i), 1'b0, 1'b0);
    wait_start("t1_start");
    wait_done("t1_done");
    #1;
    check("t1_start_once", start_count - s_start, 1);
    check("t1_done_once", done_count - s_done, 1);
    check("t1_busy_cycles", busy_cycles - s_busy, 224);
    check("t1_re5", frame_re[5], 16'h0005);
    check("t1_im5", frame_im[5], 16'hFFFB);
    check("t1_re63", frame_re[63], 16'h003F);

    // T2: short frame of 10, inverse direction
    for (int i = 0; i < 10; i++) send(16'h7FFF, 16'(i), i == 9, i == 0);
    wait_start("t2_start");
    #1;
    check("t2_ifft", fft_ifft, 1);
    check("t2_re9", frame_re[9], 16'h7FFF);
    check("t2_re10", frame_re[10], 16'h0000);
    check("t2_im63", frame_im[63], 16'h0000);
    wait_done("t2_done");

    // T3: back-to-back frames A then B, B lands in FULL
    for (int i = 0; i < N; i++) send(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      a_re[i] = 16'($urandom);
      a_im[i] = 16'($urandom);
      send(a_re[i], a_im[i], 1'b0, i == 0);
    end
    #1;
    check("t3_full_not_ready", in_ready, 0);
    check("t3_busy_while_full", busy, 1);
    wait_done("t3_done_a");
    @(negedge clk);
    check("t3_start_after_done", fft_start, 1);
    check("t3_b_re0", frame_re[0], a_re[0]);
    check("t3_b_im63", frame_im[63], a_im[63]);
    check("t3_b_ifft", fft_ifft, 1);
    @(negedge clk);
    wait_done("t3_done_b");

    // T4: completion on the edge where the run ends
    for (int i = 0; i < N; i++) send(16'($urandom), 16'($urandom), 1'b0, 1'b0);
    wait_start("t4_start_c");
    s = cyc;
    for (int i = 0; i < N - 1; i++) send(16'(i + 500), 16'(i), 1'b0, 1'b0);
    while (cyc < s + LAT - 1) @(negedge clk);
    send(16'h1234, 16'h5678, 1'b0, 1'b0);
    check("t4_done_now", done, 1);
    check("t4_no_start_yet", fft_start, 0);
    @(negedge clk);
    check("t4_start_next", fft_start, 1);
    check("t4_done_gone", done, 0);
    check("t4_re63", frame_re[63], 16'h1234);
    @(negedge clk);
    wait_done("t4_done_d");

    // T5: random valid gaps must not drop or duplicate samples
    for (int i = 0; i < N; i++) begin
      while ($urandom_range(1) == 1) @(negedge clk);
      send(16'(i), 16'(-i), 1'b0, 1'b0);
    end
    wait_start("t5_start");
    #1;
    errs = 0;
    for (int i = 0; i < N; i++)
      if (frame_re[i] !== 16'(i) || frame_im[i] !== 16'(-i)) errs++;
    check("t5_buf_errs", errs, 0);
    wait_done("t5_done");

    // T6: reset mid-run with 20 samples of the next frame buffered
    for (int i = 0; i < N; i++) send(16'(i + 1), 16'(i + 1), 1'b0, 1'b1);
    wait_start("t6_start_e");
    for (int i = 0; i < 20; i++) send(16'(i + 900), 16'(i), 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t6_busy_clr", busy, 0);
    check("t6_start_clr", fft_start, 0);
    check("t6_done_clr", done, 0);
    check("t6_ifft_clr", fft_ifft, 0);
    check("t6_re0_clr", frame_re[0], 0);
    check("t6_re19_clr", frame_re[19], 0);
    check("t6_re40_clr", frame_re[40], 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) send(16'(i + 100), 16'(i), 1'b0, 1'b0);
    wait_start("t6_start_fresh");
    #1;
    check("t6_fresh_re0", frame_re[0], 16'd100);
    check("t6_fresh_re63", frame_re[63], 16'd163);
    wait_done("t6_done_fresh");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
